// File: rtl/regfile_bt_pkg.sv
// regfile_bt_pkg: sequencer state type and register-index helpers shared by the register file
package regfile_bt_pkg;

    typedef enum logic [1:0] {IDLE, STORE, LOAD, DONE} bt_state_t;

    localparam int MAX_DEPTH = 32;

    function automatic int pc_idx(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

    function automatic logic [4:0] lowest_set(input logic [MAX_DEPTH-1:0] mask);
        logic [4:0] r;
        r = '0;
        for (int i = MAX_DEPTH - 1; i >= 0; i--)
            if (mask[i]) r = 5'(i);
        return r;
    endfunction

endpackage

// File: rtl/regfile_bt_seq.sv
// regfile_bt_seq: block-transfer sequencer walking a register mask in ascending order
module regfile_bt_seq
    import regfile_bt_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  bt_start,
    input  logic                  bt_load,
    input  logic [2**ADDR_W-1:0]  bt_mask,
    input  logic                  bt_out_ready,
    input  logic                  bt_in_valid,
    output logic                  bt_busy,
    output logic                  bt_done,
    output logic                  bt_out_valid,
    output logic                  bt_in_ready,
    output logic [ADDR_W-1:0]     idx,
    output logic                  wr_beat
);

    localparam int DEPTH = 2**ADDR_W;

    bt_state_t        state, state_n;
    logic [DEPTH-1:0] m, m_n, m_clr;
    logic             beat;

    assign idx          = ADDR_W'(lowest_set(MAX_DEPTH'(m)));
    assign bt_busy      = state != IDLE;
    assign bt_done      = state == DONE;
    assign bt_out_valid = state == STORE;
    assign bt_in_ready  = state == LOAD;
    assign wr_beat      = bt_in_ready && bt_in_valid;

    // next state and pending mask; each accepted beat retires the lowest pending register
    always_comb begin
        state_n = state;
        m_n     = m;
        beat    = (bt_out_valid && bt_out_ready) || wr_beat;
        m_clr   = m & ~(DEPTH'(1) << idx);
        case (state)
            IDLE: if (bt_start) begin
                m_n     = bt_mask;
                state_n = (bt_mask == '0) ? DONE : (bt_load ? LOAD : STORE);
            end
            STORE, LOAD: if (beat) begin
                m_n     = m_clr;
                state_n = (m_clr == '0) ? DONE : state;
            end
            default: state_n = IDLE;
        endcase
    end

    // state and mask registers; reset aborts any transfer in flight
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            m     <= '0;
        end else begin
            state <= state_n;
            m     <= m_n;
        end
    end

endmodule

// File: rtl/regfile_bt.sv
// regfile_bt: register file with PC shadow, optional write bypass and block-transfer port
module regfile_bt
    import regfile_bt_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3,
    parameter bit BYPASS = 1
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 RegWrite,
    input  logic [ADDR_W-1:0]    A1,
    input  logic [ADDR_W-1:0]    A2,
    input  logic [ADDR_W-1:0]    A3,
    input  logic [WIDTH-1:0]     WD3,
    input  logic [WIDTH-1:0]     PC,
    output logic [WIDTH-1:0]     RD1,
    output logic [WIDTH-1:0]     RD2,
    input  logic                 bt_start,
    input  logic                 bt_load,
    input  logic [2**ADDR_W-1:0] bt_mask,
    output logic                 bt_busy,
    output logic                 bt_done,
    output logic                 bt_out_valid,
    input  logic                 bt_out_ready,
    output logic [ADDR_W-1:0]    bt_out_idx,
    output logic [WIDTH-1:0]     bt_out_data,
    input  logic                 bt_in_valid,
    output logic                 bt_in_ready,
    input  logic [WIDTH-1:0]     bt_in_data,
    output logic [ADDR_W-1:0]    bt_in_idx
);

    localparam int                DEPTH  = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(pc_idx(ADDR_W));

    logic [WIDTH-1:0]  regs [DEPTH];
    logic [ADDR_W-1:0] idx, wa;
    logic [WIDTH-1:0]  wd;
    logic              wr_beat, we;

    regfile_bt_seq #(.ADDR_W(ADDR_W)) u_seq (
        .CLK          (CLK),
        .rst          (rst),
        .bt_start     (bt_start),
        .bt_load      (bt_load),
        .bt_mask      (bt_mask),
        .bt_out_ready (bt_out_ready),
        .bt_in_valid  (bt_in_valid),
        .bt_busy      (bt_busy),
        .bt_done      (bt_done),
        .bt_out_valid (bt_out_valid),
        .bt_in_ready  (bt_in_ready),
        .idx          (idx),
        .wr_beat      (wr_beat)
    );

    // the sequencer owns the write port while busy; the PC shadow slot is never written
    assign wa = wr_beat ? idx : A3;
    assign wd = wr_beat ? bt_in_data : WD3;
    assign we = (wr_beat || (RegWrite && !bt_busy)) && (wa != PC_IDX);

    assign RD1         = (BYPASS && we && (A1 == wa)) ? wd : regs[A1];
    assign RD2         = (BYPASS && we && (A2 == wa)) ? wd : regs[A2];
    assign bt_out_idx  = idx;
    assign bt_in_idx   = idx;
    assign bt_out_data = regs[idx];

    // storage: top slot samples PC every cycle, the rest take the single committed write
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= (i == int'(PC_IDX)) ? PC : ((we && wa == ADDR_W'(i)) ? wd : regs[i]);
        end
    end

endmodule

// File: tb/tb_regfile_bt.sv
// tb_regfile_bt: scoreboard bench for reads, bypass, PC shadow and block transfers
module tb_regfile_bt;

    typedef struct {
        string      name;
        logic [7:0] rd1;
        logic [7:0] rd2;
        logic [7:0] rd2nb;
        logic [3:0] st;
    } rd_t;

    typedef struct {
        logic [2:0] idx;
        logic [7:0] data;
        int         cyc;
    } beat_t;

    logic       CLK = 0, rst = 1;
    logic       RegWrite = 0, bt_start = 0, bt_load = 0, bt_out_ready = 0, bt_in_valid = 0;
    logic [2:0] A1 = 0, A2 = 0, A3 = 0;
    logic [7:0] WD3 = 0, PC = 0, bt_mask = 0, bt_in_data = 0;

    logic [7:0] RD1, RD2, bt_out_data, n_RD1, n_RD2, n_bt_out_data;
    logic [2:0] bt_out_idx, bt_in_idx, n_bt_out_idx, n_bt_in_idx;
    logic       bt_busy, bt_done, bt_out_valid, bt_in_ready;
    logic       n_bt_busy, n_bt_done, n_bt_out_valid, n_bt_in_ready;

    rd_t   rd_q[$];
    beat_t out_q[$];
    beat_t in_q[$];
    int    done_q[$];
    logic  rd_req = 0;
    int    cyc = 0, checks = 0, errors = 0;
    rd_t   rx;
    beat_t bx;
    int    dx;

    regfile_bt #(.WIDTH(8), .ADDR_W(3), .BYPASS(1)) dut (
        .CLK(CLK), .rst(rst), .RegWrite(RegWrite), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .PC(PC),
        .RD1(RD1), .RD2(RD2), .bt_start(bt_start), .bt_load(bt_load), .bt_mask(bt_mask),
        .bt_busy(bt_busy), .bt_done(bt_done), .bt_out_valid(bt_out_valid), .bt_out_ready(bt_out_ready),
        .bt_out_idx(bt_out_idx), .bt_out_data(bt_out_data), .bt_in_valid(bt_in_valid),
        .bt_in_ready(bt_in_ready), .bt_in_data(bt_in_data), .bt_in_idx(bt_in_idx)
    );

    regfile_bt #(.WIDTH(8), .ADDR_W(3), .BYPASS(0)) dut_nb (
        .CLK(CLK), .rst(rst), .RegWrite(RegWrite), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .PC(PC),
        .RD1(n_RD1), .RD2(n_RD2), .bt_start(bt_start), .bt_load(bt_load), .bt_mask(bt_mask),
        .bt_busy(n_bt_busy), .bt_done(n_bt_done), .bt_out_valid(n_bt_out_valid), .bt_out_ready(bt_out_ready),
        .bt_out_idx(n_bt_out_idx), .bt_out_data(n_bt_out_data), .bt_in_valid(bt_in_valid),
        .bt_in_ready(n_bt_in_ready), .bt_in_data(bt_in_data), .bt_in_idx(n_bt_in_idx)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // monitor: compare every DUT event against the front of the matching queue
    always @(negedge CLK) begin
        if (rd_req) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_underflow: read check with no expectation at cyc=%0d", cyc);
            end else begin
                rx = rd_q.pop_front();
                if ({RD1, RD2, n_RD2, bt_busy, bt_done, bt_out_valid, bt_in_ready} !==
                    {rx.rd1, rx.rd2, rx.rd2nb, rx.st}) begin
                    errors++;
                    $display("FAIL %s: got rd1=%h rd2=%h rd2_nobyp=%h status=%b, expected %h %h %h %b",
                             rx.name, RD1, RD2, n_RD2, {bt_busy, bt_done, bt_out_valid, bt_in_ready},
                             rx.rd1, rx.rd2, rx.rd2nb, rx.st);
                end
            end
        end
        if (bt_out_valid === 1'b1) begin
            checks++;
            if (out_q.size() == 0) begin
                errors++;
                $display("FAIL store_unexpected: idx=%0d data=%h at cyc=%0d, expected no beat", bt_out_idx, bt_out_data, cyc);
            end else begin
                bx = out_q[0];
                if (bt_out_ready) void'(out_q.pop_front());
                if ({bt_out_idx, bt_out_data} !== {bx.idx, bx.data} || (bt_out_ready && cyc != bx.cyc)) begin
                    errors++;
                    $display("FAIL store_beat: got idx=%0d data=%h cyc=%0d ready=%b, expected idx=%0d data=%h cyc=%0d",
                             bt_out_idx, bt_out_data, cyc, bt_out_ready, bx.idx, bx.data, bx.cyc);
                end
            end
        end
        if (bt_in_valid && bt_in_ready === 1'b1) begin
            checks++;
            if (in_q.size() == 0) begin
                errors++;
                $display("FAIL load_unexpected: idx=%0d at cyc=%0d, expected no beat", bt_in_idx, cyc);
            end else begin
                bx = in_q.pop_front();
                if (bt_in_idx !== bx.idx || cyc != bx.cyc) begin
                    errors++;
                    $display("FAIL load_beat: got idx=%0d cyc=%0d, expected idx=%0d cyc=%0d", bt_in_idx, cyc, bx.idx, bx.cyc);
                end
            end
        end
        if (bt_done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: at cyc=%0d, expected none", cyc);
            end else begin
                dx = done_q.pop_front();
                if (cyc != dx) begin
                    errors++;
                    $display("FAIL done: got cyc=%0d expected cyc=%0d", cyc, dx);
                end
            end
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
        rd_req = 0;
    endtask

    task automatic rdchk(input string n, input logic [7:0] e1, input logic [7:0] e2,
                         input logic [7:0] e2nb, input logic [3:0] st);
        rd_q.push_back('{name: n, rd1: e1, rd2: e2, rd2nb: e2nb, st: st});
        rd_req = 1;
    endtask

    task automatic leftover(input string n, input int sz);
        checks++;
        if (sz != 0) begin
            errors++;
            $display("FAIL leftover_%s: got %0d pending entries, expected 0", n, sz);
        end
    endtask

    // directed stimulus; expectations are pushed as each vector is applied
    initial begin
        tick; tick;
        A1 = 3; A2 = 7;
        rdchk("reset", 8'h00, 8'h00, 8'h00, 4'b0000); tick;
        rst = 0;
        RegWrite = 1; A3 = 2; WD3 = 8'h5A; A1 = 0; A2 = 2;
        rdchk("bypass", 8'h00, 8'h5A, 8'h00, 4'b0000); tick;
        A3 = 0; WD3 = 8'h33; A1 = 2;
        rdchk("write", 8'h5A, 8'h5A, 8'h5A, 4'b0000); tick;
        RegWrite = 0; PC = 8'h10; A1 = 7; A2 = 0;
        rdchk("pc_old", 8'h00, 8'h33, 8'h33, 4'b0000); tick;
        PC = 8'h11; RegWrite = 1; A3 = 7; WD3 = 8'hFF; A2 = 7;
        rdchk("pc_lag", 8'h10, 8'h10, 8'h10, 4'b0000); tick;
        RegWrite = 0;
        rdchk("pc_nowrite", 8'h11, 8'h11, 8'h11, 4'b0000); tick;

        bt_start = 1; bt_load = 0; bt_mask = 8'h85; bt_out_ready = 1; A1 = 0; A2 = 2;
        out_q.push_back('{3'd0, 8'h33, cyc + 1});
        out_q.push_back('{3'd2, 8'h5A, cyc + 2});
        out_q.push_back('{3'd7, 8'h11, cyc + 3});
        done_q.push_back(cyc + 4);
        rdchk("store_start", 8'h33, 8'h5A, 8'h5A, 4'b0000); tick;
        bt_load = 1; bt_mask = 8'h02;
        rdchk("store_busy", 8'h33, 8'h5A, 8'h5A, 4'b1010); tick;
        bt_start = 0; bt_load = 0; tick; tick; tick;

        bt_start = 1; bt_mask = 8'h00;
        done_q.push_back(cyc + 1);
        rdchk("zero_start", 8'h33, 8'h5A, 8'h5A, 4'b0000); tick;
        bt_start = 0;
        rdchk("zero_done", 8'h33, 8'h5A, 8'h5A, 4'b1100); tick;

        bt_start = 1; bt_load = 1; bt_mask = 8'h06;
        in_q.push_back('{3'd1, 8'h00, cyc + 1});
        in_q.push_back('{3'd2, 8'h00, cyc + 3});
        done_q.push_back(cyc + 4);
        tick;
        bt_start = 0; bt_in_valid = 1; bt_in_data = 8'hA1; RegWrite = 1; A3 = 1; WD3 = 8'hEE; A1 = 1; A2 = 1;
        rdchk("load_bypass", 8'hA1, 8'hA1, 8'h00, 4'b1001); tick;
        bt_in_valid = 0;
        rdchk("load_gap", 8'hA1, 8'hA1, 8'hA1, 4'b1001); tick;
        bt_in_valid = 1; bt_in_data = 8'hB2; RegWrite = 0; A1 = 2; A2 = 2;
        rdchk("load_beat2", 8'hB2, 8'hB2, 8'h5A, 4'b1001); tick;
        bt_in_valid = 0; tick;
        A1 = 1; A2 = 2;
        rdchk("load_after", 8'hA1, 8'hB2, 8'hB2, 4'b0000); tick;

        bt_start = 1; bt_load = 0; bt_mask = 8'h02; bt_out_ready = 0; A2 = 1;
        out_q.push_back('{3'd1, 8'hA1, cyc + 4});
        done_q.push_back(cyc + 5);
        tick;
        bt_start = 0;
        for (int i = 0; i < 3; i++) begin
            rdchk("store_hold", 8'hA1, 8'hA1, 8'hA1, 4'b1010); tick;
        end
        bt_out_ready = 1; tick; tick;

        bt_start = 1; bt_load = 1; bt_mask = 8'h0C; bt_in_valid = 1; bt_in_data = 8'h77;
        in_q.push_back('{3'd2, 8'h00, cyc + 1});
        tick;
        bt_start = 0; tick;
        rst = 1; bt_in_valid = 0; A1 = 2; A2 = 7;
        rdchk("reset_abort", 8'h00, 8'h00, 8'h00, 4'b0000); tick;
        rst = 0; tick;
        A1 = 2; A2 = 0;
        rdchk("after_reset", 8'h00, 8'h00, 8'h00, 4'b0000); tick;
        tick; tick; tick;

        leftover("reads", rd_q.size());
        leftover("store", out_q.size());
        leftover("load", in_q.size());
        leftover("done", done_q.size());
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
